// File: rtl/cpu_types_pkg.sv
// Shared fetch-stage types: FSM state, buffer entry layout and J-type decode helpers.
package cpu_types_pkg;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } fetch_state_t;

   localparam logic [5:0] J_OPCODE = 6'b000010;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] npc;
      logic [31:0] curr_pc;
   } fetch_entry_t;

   // Jump target keeps the upper nibble of the delay-slot PC.
   function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                               input logic [25:0] index);
      jump_target = {pc_plus4[31:28], index, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular buffer of fetched instructions with push, pop, flush and occupancy count.
module fetch_buffer
   import cpu_types_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  fetch_entry_t                 wdata,
   output fetch_entry_t                 rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t    mem_q [DEPTH];
   fetch_entry_t    mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_push_s, do_pop_s;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      ptr_next = (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      do_push_s = push & (count_q != CW'(DEPTH));
      do_pop_s  = pop & (count_q != {CW{1'b0}});
      if (flush) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ptr_next(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         rd_ptr_d = do_pop_s ? ptr_next(rd_ptr_q) : rd_ptr_q;
         case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata = (count_q == {CW{1'b0}}) ? fetch_entry_t'('0) : mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the IF/ID latch through a small buffer.
// Optional macro FETCH_JPRED_EN: follow J-type jumps at fetch time.
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] PC_INIT   = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   input  logic        freeze,
   output logic [31:0] instr_o,
   output logic [31:0] npc_o,
   output logic [31:0] curr_pc_o,
   output logic        en_o,
   output logic        flush_o
);

   localparam int CW = $clog2(BUF_DEPTH + 1);

   fetch_state_t   state_q, state_d;
   logic [31:0]    pc_q, pc_d;
   logic [CW-1:0]  count_s;
   logic           run_s, req_s, push_s, pop_s, flush_s;
   logic [31:0]    pc_plus4_s, seq_pc_s;
   fetch_entry_t   wdata_s, head_s;

   always_comb begin
      run_s      = (state_q == ST_RUN);
      req_s      = run_s & ~redirect & (count_s != CW'(BUF_DEPTH));
      push_s     = req_s & ihit;
      pop_s      = run_s & (count_s != {CW{1'b0}}) & ~freeze & ~redirect;
      flush_s    = run_s & redirect;
      pc_plus4_s = pc_q + 32'd4;
`ifdef FETCH_JPRED_EN
      seq_pc_s   = (imemload[31:26] == J_OPCODE) ? jump_target(pc_plus4_s, imemload[25:0])
                                                 : pc_plus4_s;
`else
      seq_pc_s   = pc_plus4_s;
`endif
      wdata_s    = '{instr: imemload, npc: pc_plus4_s, curr_pc: pc_q};
   end

   // Halt beats a simultaneous redirect: the path is flushed but the PC stays put.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         ST_RUN: begin
            state_d = halt ? ST_HALTED : ST_RUN;
            if (flush_s && !halt) begin
               pc_d = redirect_pc;
            end else if (push_s) begin
               pc_d = seq_pc_s;
            end else begin
               pc_d = pc_q;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
            pc_d    = pc_q;
         end
         default: begin
            state_d = ST_RUN;
            pc_d    = pc_q;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_RUN;
         pc_q    <= PC_INIT;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push_s),
      .pop   (pop_s),
      .flush (flush_s),
      .wdata (wdata_s),
      .rdata (head_s),
      .count (count_s)
   );

   assign imemREN   = req_s;
   assign imemaddr  = pc_q;
   assign instr_o   = head_s.instr;
   assign npc_o     = head_s.npc;
   assign curr_pc_o = head_s.curr_pc;
   assign en_o      = pop_s | flush_s;
   assign flush_o   = flush_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a simple address-derived instruction memory.
module tb_fetch_unit;

   logic        CLK;
   logic        RST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        freeze;
   logic [31:0] instr_o;
   logic [31:0] npc_o;
   logic [31:0] curr_pc_o;
   logic        en_o;
   logic        flush_o;
   logic        jmode;

   int n_run  = 0;
   int n_fail = 0;

`ifdef FETCH_JPRED_EN
   localparam logic [31:0] PC_AFTER_J = 32'h0000_0100;
`else
   localparam logic [31:0] PC_AFTER_J = 32'h0000_0014;
`endif

   fetch_unit dut (
      .CLK         (CLK),
      .RST         (RST),
      .imemREN     (imemREN),
      .imemaddr    (imemaddr),
      .ihit        (ihit),
      .imemload    (imemload),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .freeze      (freeze),
      .instr_o     (instr_o),
      .npc_o       (npc_o),
      .curr_pc_o   (curr_pc_o),
      .en_o        (en_o),
      .flush_o     (flush_o)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Memory returns lw-opcode words tagged with the address; jmode plants a J at 0x10.
   assign imemload = (jmode && imemaddr == 32'h0000_0010) ? 32'h0800_0040
                                                          : {6'b100011, imemaddr[25:0]};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; ihit = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      halt = 1'b0; freeze = 1'b0; jmode = 1'b0;
      #12;
      check("rst_addr",  imemaddr,  32'h0);
      check("rst_instr", instr_o,   32'h0);
      check("rst_curr",  curr_pc_o, 32'h0);
      check("rst_en",    32'(en_o),    32'h0);
      check("rst_flush", 32'(flush_o), 32'h0);

      RST = 1'b0; ihit = 1'b1; #1;
      check("c0_ren",  32'(imemREN), 32'h1);
      check("c0_addr", imemaddr,     32'h0);
      check("c0_en",   32'(en_o),    32'h0);

      tick();
      check("c1_addr",  imemaddr,  32'h4);
      check("c1_curr",  curr_pc_o, 32'h0);
      check("c1_instr", instr_o,   32'h8C00_0000);
      check("c1_npc",   npc_o,     32'h4);
      check("c1_en",    32'(en_o), 32'h1);

      tick();
      check("c2_addr", imemaddr,  32'h8);
      check("c2_curr", curr_pc_o, 32'h4);
      freeze = 1'b1; #1;
      check("frz_en0",  32'(en_o),    32'h0);
      check("frz_ren0", 32'(imemREN), 32'h1);

      repeat (3) begin
         tick();
         check("frz_full_ren", 32'(imemREN), 32'h0);
         check("frz_addr",     imemaddr,     32'hC);
         check("frz_hold",     instr_o,      32'h8C00_0004);
         check("frz_en",       32'(en_o),    32'h0);
      end
      freeze = 1'b0; #1;
      check("rel_en",   32'(en_o),    32'h1);
      check("rel_curr", curr_pc_o,    32'h4);
      check("rel_ren",  32'(imemREN), 32'h0);

      tick();
      check("pop2_curr", curr_pc_o,    32'h8);
      check("pop2_ren",  32'(imemREN), 32'h1);
      check("pop2_addr", imemaddr,     32'hC);

      tick();
      check("seq_curr", curr_pc_o, 32'hC);
      check("seq_addr", imemaddr,  32'h10);
      ihit = 1'b0; #1;
      check("miss_en",  32'(en_o),    32'h1);
      check("miss_ren", 32'(imemREN), 32'h1);

      tick();
      check("miss1_addr",  imemaddr,     32'h10);
      check("miss1_empty", instr_o,      32'h0);
      check("miss1_en",    32'(en_o),    32'h0);
      check("miss1_ren",   32'(imemREN), 32'h1);
      tick();
      check("miss2_addr", imemaddr, 32'h10);
      ihit = 1'b1; #1;

      tick();
      check("hit_addr",  imemaddr,  32'h14);
      check("hit_curr",  curr_pc_o, 32'h10);
      check("hit_instr", instr_o,   32'h8C00_0010);
      freeze = 1'b1; #1;

      tick();
      check("full_ren", 32'(imemREN), 32'h0);
      redirect = 1'b1; redirect_pc = 32'h0000_0100; #1;
      check("redir_flush", 32'(flush_o), 32'h1);
      check("redir_en",    32'(en_o),    32'h1);
      check("redir_ren",   32'(imemREN), 32'h0);

      tick();
      redirect = 1'b0; freeze = 1'b0; #1;
      check("redir_addr",  imemaddr,     32'h100);
      check("redir_empty", instr_o,      32'h0);
      check("redir_en0",   32'(en_o),    32'h0);
      check("redir_fl0",   32'(flush_o), 32'h0);

      tick();
      check("tgt_curr",  curr_pc_o, 32'h100);
      check("tgt_instr", instr_o,   32'h8C00_0100);
      check("tgt_npc",   npc_o,     32'h104);
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;

      tick();
      redirect = 1'b0; #1;
      check("wrap_addr0", imemaddr, 32'hFFFF_FFFC);

      tick();
      check("wrap_addr",  imemaddr,  32'h0);
      check("wrap_npc",   npc_o,     32'h0);
      check("wrap_curr",  curr_pc_o, 32'hFFFF_FFFC);
      check("wrap_instr", instr_o,   32'h8FFF_FFFC);
      jmode = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0010; #1;

      tick();
      redirect = 1'b0; #1;
      check("j_addr0", imemaddr, 32'h10);

      tick();
      check("j_next",  imemaddr,  PC_AFTER_J);
      check("j_npc",   npc_o,     32'h14);
      check("j_curr",  curr_pc_o, 32'h10);
      check("j_instr", instr_o,   32'h0800_0040);
      jmode = 1'b0; halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200; #1;
      check("hr_flush", 32'(flush_o), 32'h1);
      check("hr_ren",   32'(imemREN), 32'h0);

      tick();
      halt = 1'b0; redirect = 1'b0; #1;
      check("hlt_ren",   32'(imemREN), 32'h0);
      check("hlt_addr",  imemaddr,     PC_AFTER_J);
      check("hlt_empty", instr_o,      32'h0);
      check("hlt_en",    32'(en_o),    32'h0);
      redirect = 1'b1; redirect_pc = 32'h0000_0300; #1;
      check("hlt_redir_fl", 32'(flush_o), 32'h0);
      check("hlt_redir_en", 32'(en_o),    32'h0);

      tick();
      redirect = 1'b0; #1;
      check("hlt_hold_addr", imemaddr,     PC_AFTER_J);
      check("hlt_hold_ren",  32'(imemREN), 32'h0);

      RST = 1'b1; #1;
      check("arst_addr",  imemaddr, 32'h0);
      check("arst_instr", instr_o,  32'h0);
      RST = 1'b0; #1;
      check("post_ren",  32'(imemREN), 32'h1);
      check("post_addr", imemaddr,     32'h0);

      tick();
      check("post_curr", curr_pc_o, 32'h0);
      check("post_next", imemaddr,  32'h4);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
